// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg
// Shared definitions for the pipeline hazard sequencer:
//   - hz_state_e      : sequencer FSM states (RUN, DRAIN, FLUSH)
//   - *_DEF constants : default NUM_STAGES / WDOG_W / PERF_W values
package pipe_hazard_pkg;

   localparam int NUM_STAGES_DEF = 5;
   localparam int WDOG_W_DEF     = 8;
   localparam int PERF_W_DEF     = 32;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

endpackage

// File: rtl/pipe_stall_watchdog.sv
// pipe_stall_watchdog
// Counts consecutive cycles with stall_any high and raises a sticky error
// once the count reaches 2^WDOG_W-1.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   stall_any    : a stall is being honoured this cycle
//   clr          : clears the sticky error (trap commit)
//   err          : sticky stall-timeout flag
module pipe_stall_watchdog
   import pipe_hazard_pkg::*;
#(
   parameter int WDOG_W = WDOG_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic stall_any,
   input  logic clr,
   output logic err
);

   localparam logic [WDOG_W-1:0] CNT_MAX = '1;

   logic [WDOG_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (!stall_any)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;

         // The error is raised on the edge at which the count reaches its
         // maximum, and re-raised if the stall persists after a clear.
         if (clr)
            err <= 1'b0;
         else if (stall_any && (cnt >= CNT_MAX - 1'b1))
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
// Central stall / flush / trap sequencer for an in-order pipeline.
// Register index 0 is the PC, index j is the register feeding stage j.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   stall_req, flush_req  : per-stage stall / redirect requests (level)
//   trap, trap_ret        : trap and xRET requests from the CSR unit
//   mem_busy              : data-bus transaction outstanding
//   reg_en, reg_clr       : per-register enable / synchronous clear
//   trap_ack              : one-cycle commit pulse of a trap or xRET
//   flush_taken           : a redirect flush is applied this cycle
//   wdog_err              : sticky stall-timeout flag
//   stall_cycles, flush_count, trap_count : performance counters
// Build option: define PIPE_HAZARD_PERF_EN to build the performance
// counters; otherwise the counter outputs are tied to zero.
module pipeline_hazard_sequencer
   import pipe_hazard_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int WDOG_W     = WDOG_W_DEF,
   parameter int PERF_W     = PERF_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic [NUM_STAGES-1:0] flush_req,
   input  logic                  trap,
   input  logic                  trap_ret,
   input  logic                  mem_busy,
   output logic [NUM_STAGES-1:0] reg_en,
   output logic [NUM_STAGES-1:0] reg_clr,
   output logic                  trap_ack,
   output logic                  flush_taken,
   output logic                  wdog_err,
   output logic [PERF_W-1:0]     stall_cycles,
   output logic [PERF_W-1:0]     flush_count,
   output logic [PERF_W-1:0]     trap_count
);

   localparam logic [NUM_STAGES-1:0] LAST_ONLY = {1'b1, {(NUM_STAGES-1){1'b0}}};
   localparam logic [NUM_STAGES-1:0] ALL_BUT_PC = {{(NUM_STAGES-1){1'b1}}, 1'b0};

   // Bit i is set when any request at index >= i is set, i.e. bits 0..k
   // for the highest requesting index k.
   function automatic logic [NUM_STAGES-1:0] cover_below(input logic [NUM_STAGES-1:0] v);
      logic [NUM_STAGES-1:0] m;
      logic                  seen;
      seen = 1'b0;
      m    = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         seen = seen | v[i];
         m[i] = seen;
      end
      return m;
   endfunction

   hz_state_e state, state_nxt;

   logic [NUM_STAGES-1:0] stall_cover, stall_bub;
   logic [NUM_STAGES-1:0] flush_cover, flush_hot, flush_clr;
   logic                  flush_ok;
   logic                  flush_apply;

   always_comb begin
      stall_cover = cover_below(stall_req);
      // Bubble goes into the register just past the oldest stalled stage;
      // the shift drops it when that stage is the last one.
      stall_bub   = (stall_cover << 1) & ~stall_cover;
      flush_cover = cover_below(flush_req);
      flush_hot   = flush_cover & ~(flush_cover >> 1);
      flush_clr   = ((flush_cover << 1) | flush_cover) & ALL_BUT_PC;
      // A stall at or beyond the redirecting stage means that stage has not
      // really resolved yet; the requester keeps flush_req asserted.
      flush_ok    = (|flush_req) && !(|(stall_cover & flush_hot));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   // trap and trap_ret drive the identical drain/flush sequence, so trap
   // taking precedence needs no separate bookkeeping: once the sequence is
   // entered further requests are not sampled until it returns to RUN.
   always_comb begin
      state_nxt   = state;
      reg_en      = '1;
      reg_clr     = '0;
      trap_ack    = 1'b0;
      flush_apply = 1'b0;
      case (state)
         ST_RUN: begin
            if (trap || trap_ret) begin
               // Hold the pipe while the redirect is pending; writeback retires.
               reg_en    = LAST_ONLY;
               state_nxt = mem_busy ? ST_DRAIN : ST_FLUSH;
            end else begin
               reg_clr = stall_bub;
               reg_en  = ~stall_cover;
               if (flush_ok) begin
                  reg_clr     = reg_clr | flush_clr;
                  flush_apply = 1'b1;
               end
               // A clear only lands if the register is enabled.
               reg_en = reg_en | reg_clr;
               if (flush_ok)
                  reg_en[0] = 1'b1;
            end
         end
         ST_DRAIN: begin
            reg_en = LAST_ONLY;
            if (!mem_busy)
               state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            reg_clr   = ALL_BUT_PC;
            trap_ack  = 1'b1;
            state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Register enables keep following the RUN equations in reset, but the
   // flush indication itself is suppressed.
   assign flush_taken = flush_apply & reset_n;

   pipe_stall_watchdog #(
      .WDOG_W (WDOG_W)
   ) u_wdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .stall_any ((state == ST_RUN) && (|stall_req)),
      .clr       (trap_ack),
      .err       (wdog_err)
   );

`ifdef PIPE_HAZARD_PERF_EN
   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic inc);
      return (inc && (v != PERF_MAX)) ? v + 1'b1 : v;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
         trap_count   <= '0;
      end else begin
         stall_cycles <= sat_inc(stall_cycles, ~&reg_en);
         flush_count  <= sat_inc(flush_count, flush_taken);
         trap_count   <= sat_inc(trap_count, trap_ack);
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
   assign trap_count   = '0;
`endif

endmodule

// File: doc/pipeline_hazard_sequencer.md
PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 5, number of pipeline registers incl. PC (index 0 = PC, index j = register feeding stage j), legal 3..8.
REQ-002 Parameter WDOG_W, default 8, stall-watchdog counter width.
REQ-003 Parameter PERF_W, default 32, performance-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 stall_req  in  NUM_STAGES  level; bit k = stage k cannot advance (load-use, bus wait, atomic).
REQ-007 flush_req  in  NUM_STAGES  level; bit k = stage k resolved a redirect (branch/jump).
REQ-008 trap  in  1  level trap request from CSR unit; trap_ret  in  1  level xRET request.
REQ-009 mem_busy  in  1  outstanding data-bus transaction.
REQ-010 reg_en  out  NUM_STAGES  per-register enable; reg_clr  out  NUM_STAGES  per-register synchronous clear (bubble).
REQ-011 trap_ack  out  1  one-cycle pulse: CSR commits trap/xRET, PC redirected.
REQ-012 flush_taken  out  1  flush applied this cycle; wdog_err  out  1  sticky stall-timeout flag.
REQ-013 stall_cycles, flush_count, trap_count  out  PERF_W each  performance counters.

Function
REQ-014 FSM states RUN, DRAIN, FLUSH; transitions evaluated each rising edge.
REQ-015 RUN, no trap/trap_ret: s = highest k with stall_req[k]; reg_en[0..s]=0, reg_clr[s+1]=1 if s+1<NUM_STAGES; all other reg_en=1.
REQ-016 RUN: f = highest k with flush_req[k]; flush applied only if no stall_req index >= f; then reg_clr[1..min(f+1,NUM_STAGES-1)]=1, reg_en[0]=1, flush_taken=1.
REQ-017 Flush blocked by older stall: no clears from flush, flush_taken=0; requester holds flush_req.
REQ-018 Stall and clear on same register: clear wins.
REQ-019 RUN with trap or trap_ret and mem_busy=1 -> DRAIN; trap or trap_ret with mem_busy=0 -> FLUSH next cycle.
REQ-020 Simultaneous trap and trap_ret: trap wins; trap_ret ignored until trap_ack.
REQ-021 DRAIN: reg_en all 0 except reg_en[NUM_STAGES-1]=1 (writeback retires); leave to FLUSH on first cycle mem_busy=0.
REQ-022 FLUSH: exactly one cycle; reg_clr[1..NUM_STAGES-1]=1, reg_en all 1, trap_ack=1; -> RUN.
REQ-023 trap/trap_ret latency: 1 cycle to trap_ack with mem_busy=0; 1+N cycles when mem_busy held N cycles.
REQ-024 DRAIN/FLUSH: stall_req and flush_req ignored.
REQ-025 Watchdog: counts consecutive RUN cycles with any stall_req; clears when none; reaching 2^WDOG_W-1 sets wdog_err; wdog_err clears only on trap_ack or reset.

Reset
REQ-026 reset_n low: FSM=RUN, watchdog=0, wdog_err=0, perf counters=0, trap_ack=0, flush_taken=0; reg_en/reg_clr follow RUN equations.
REQ-027 Reset during DRAIN/FLUSH aborts the sequence; no trap_ack after reset release unless trap re-asserted.

Configuration
REQ-028 Macro PIPE_HAZARD_PERF_EN defined: stall_cycles +1 per cycle any reg_en=0, flush_count +1 per flush_taken, trap_count +1 per trap_ack; all saturate at 2^PERF_W-1.
REQ-029 PIPE_HAZARD_PERF_EN undefined: counters not built, outputs tied to 0.

Structure
REQ-030 Package pipe_hazard_pkg holds FSM state enum and default NUM_STAGES/WDOG_W/PERF_W constants.
REQ-031 Watchdog is sub-module pipe_stall_watchdog (inputs stall_any, clr; output err); rest in top module.

Verification
REQ-032 NUM_STAGES=5, stall_req=5'b00010 -> reg_en=5'b11100, reg_clr=5'b00100; wdog_err=0.
REQ-033 flush_req=5'b00100, stall_req=0 -> reg_clr=5'b01110, flush_taken=1; add stall_req=5'b01000 -> flush_taken=0, reg_clr=5'b10000.
REQ-034 trap pulse, mem_busy=1 for 3 cycles -> DRAIN 3 cycles (reg_en=5'b10000), then FLUSH reg_clr=5'b11110, trap_ack 1 cycle.
REQ-035 WDOG_W=4, stall_req[1] held 15 cycles -> wdog_err=1 cycle 15; trap -> cleared at trap_ack.
REQ-036 reset_n low mid-DRAIN -> RUN, counters 0, no trap_ack; PERF_EN build: 2 flushes + 1 trap -> flush_count=2, trap_count=1.
